// File: rtl/zeroriscy_arb_pkg.sv
// Shared types and constants for the two-master data-port arbiter.
// Master 0 is the LSU, master 1 the debug/DMA port.
package zeroriscy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } arb_state_e;

  localparam logic LSU = 1'b0;
  localparam logic DBG = 1'b1;

  function automatic logic [31:0] lane32(input logic [63:0] packed_v, input logic idx);
    return idx ? packed_v[63:32] : packed_v[31:0];
  endfunction

  function automatic logic [3:0] lane4(input logic [7:0] packed_v, input logic idx);
    return idx ? packed_v[7:4] : packed_v[3:0];
  endfunction

endpackage

// File: rtl/zeroriscy_rr_arbiter2.sv
// Two-way combinational winner selection: round-robin against the last
// granted master, or master 0 always first when fixed_prio is set.
module zeroriscy_rr_arbiter2
  import zeroriscy_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       winner
);

  always_comb begin
    winner = LSU;
    case (req)
      2'b10:   winner = DBG;
      2'b11:   winner = fixed_prio ? LSU : ~last;
      default: winner = LSU;
    endcase
  end

endmodule

// File: rtl/zeroriscy_data_arbiter.sv
// Arbitrates the LSU and debug/DMA masters onto one OBI-style data port
// with at most one outstanding transaction and zero-bubble back-to-back.
module zeroriscy_data_arbiter
  import zeroriscy_arb_pkg::*;
#(
  parameter logic FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_req_i,
  input  logic [63:0] m_addr_i,
  input  logic [1:0]  m_we_i,
  input  logic [7:0]  m_be_i,
  input  logic [63:0] m_wdata_i,
  output logic [1:0]  m_gnt_o,
  output logic [1:0]  m_rvalid_o,
  output logic [1:0]  m_err_o,
  output logic [31:0] m_rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        owner_o,
  output logic        busy_o,
  output logic        protocol_err_o,
  output logic [1:0]  state_o
);

  // Handshake: a memory request is accepted in a cycle where data_req_o and
  // data_gnt_i are both high; a master request is accepted when its m_gnt_o
  // bit is high in the same cycle. Responses are single-cycle pulses.

  arb_state_e state_q;
  logic       owner_q;
  logic       last_q;
  logic       protocol_err_q;

  logic       winner;
  logic       arbitrate;
  logic       any_req;
  logic       sel;
  logic       resp;
  logic       accept;
  logic       proto_viol;

  zeroriscy_rr_arbiter2 u_rr (
    .req        (m_req_i),
    .last       (last_q),
    .fixed_prio (FIXED_PRIO),
    .winner     (winner)
  );

  // A response in WAIT_RVALID frees the port, so arbitration can run that cycle.
  assign resp      = (state_q == WAIT_RVALID) && data_rvalid_i;
  assign arbitrate = (state_q == IDLE) || resp;
  assign any_req   = |m_req_i;
  assign sel       = arbitrate ? winner : owner_q;
  assign accept    = data_req_o && data_gnt_i;

  always_comb begin
    data_req_o = 1'b0;
    if (arbitrate) begin
      data_req_o = any_req;
    end else if (state_q == WAIT_GNT) begin
      data_req_o = m_req_i[owner_q];
    end
  end

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      data_addr_o  = lane32(m_addr_i, sel);
      data_we_o    = m_we_i[sel];
      data_be_o    = lane4(m_be_i, sel);
      data_wdata_o = lane32(m_wdata_i, sel);
    end
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    if (accept) begin
      m_gnt_o[sel] = 1'b1;
    end
    if (resp) begin
      m_rvalid_o[owner_q] = 1'b1;
      m_err_o[owner_q]    = data_err_i;
    end
  end

  assign proto_viol = (data_rvalid_i && (state_q != WAIT_RVALID)) ||
                      (data_gnt_i && !data_req_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= LSU;
      last_q         <= DBG;
      protocol_err_q <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= sel;
      end
      if (proto_viol) begin
        protocol_err_q <= 1'b1;
      end
      case (state_q)
        IDLE, WAIT_RVALID: begin
          if (arbitrate) begin
            if (any_req) begin
              owner_q <= winner;
              state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_GNT: begin
          // Owner withdrawing before a grant is legal; just release the bus.
          if (!m_req_i[owner_q]) begin
            state_q <= IDLE;
          end else if (data_gnt_i) begin
            state_q <= WAIT_RVALID;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_rdata_o      = data_rdata_i;
  assign owner_o        = owner_q;
  assign busy_o         = (state_q != IDLE) || data_req_o;
  assign protocol_err_o = protocol_err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_zeroriscy_data_arbiter.sv
// Directed bench for the data arbiter: round-robin and fixed-priority
// instances share one stimulus stream.
module tb_zeroriscy_data_arbiter;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WGNT = 2'd1;
  localparam logic [1:0]  S_WRV  = 2'd2;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req_i = '0;
  logic [63:0] m_addr_i = {A1, A0};
  logic [1:0]  m_we_i = 2'b10;
  logic [7:0]  m_be_i = 8'h3F;
  logic [63:0] m_wdata_i = {W1, W0};
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic        data_err_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  logic [1:0]  m_gnt_o, m_rvalid_o, m_err_o, state_o;
  logic [31:0] m_rdata_o, data_addr_o, data_wdata_o;
  logic        data_req_o, data_we_o, owner_o, busy_o, protocol_err_o;
  logic [3:0]  data_be_o;

  logic [1:0]  fp_gnt, fp_rvalid, fp_err, fp_state;
  logic [31:0] fp_rdata, fp_addr, fp_wdata;
  logic        fp_req, fp_we, fp_owner, fp_busy, fp_perr;
  logic [3:0]  fp_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zeroriscy_data_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_err_o(m_err_o), .m_rdata_o(m_rdata_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .owner_o(owner_o),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o), .state_o(state_o)
  );

  zeroriscy_data_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_gnt_o(fp_gnt), .m_rvalid_o(fp_rvalid),
    .m_err_o(fp_err), .m_rdata_o(fp_rdata), .data_req_o(fp_req),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(fp_addr), .data_we_o(fp_we), .data_be_o(fp_be),
    .data_wdata_o(fp_wdata), .data_rdata_i(data_rdata_i), .owner_o(fp_owner),
    .busy_o(fp_busy), .protocol_err_o(fp_perr), .state_o(fp_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic er);
    @(negedge clk);
    m_req_i = req;
    data_gnt_i = gnt;
    data_rvalid_i = rv;
    data_err_i = er;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_req_i = '0;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    #1;
    check("rst_state", state_o, S_IDLE);
    check("rst_busy", busy_o, 1'b0);
    check("rst_perr", protocol_err_o, 1'b0);
    check("rst_req", data_req_o, 1'b0);
    check("rst_addr", data_addr_o, 32'h0);
    check("rst_owner", owner_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single LSU read with same-cycle grant, response next cycle
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    check("t1_gnt", m_gnt_o, 2'b01);
    check("t1_req", data_req_o, 1'b1);
    check("t1_addr", data_addr_o, A0);
    check("t1_we", data_we_o, 1'b0);
    check("t1_be", data_be_o, 4'hF);
    check("t1_wdata", data_wdata_o, W0);
    data_rdata_i = 32'hDEADBEEF;
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    check("t1_state", state_o, S_WRV);
    check("t1_rvalid", m_rvalid_o, 2'b01);
    check("t1_err", m_err_o, 2'b00);
    check("t1_rdata", m_rdata_o, 32'hDEADBEEF);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("t1_idle", state_o, S_IDLE);

    // Both masters requesting back-to-back: RR 0,1,0,1 vs fixed 0,0,0,0
    do_reset();
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    check("rr_gnt0", m_gnt_o, 2'b01);
    check("fp_gnt0", fp_gnt, 2'b01);
    check("rr_addr0", data_addr_o, A0);
    drive(2'b11, 1'b1, 1'b1, 1'b0);
    check("rr_gnt1", m_gnt_o, 2'b10);
    check("rr_rv1", m_rvalid_o, 2'b01);
    check("rr_addr1", data_addr_o, A1);
    check("fp_gnt1", fp_gnt, 2'b01);
    check("fp_rv1", fp_rvalid, 2'b01);
    drive(2'b11, 1'b1, 1'b1, 1'b0);
    check("rr_gnt2", m_gnt_o, 2'b01);
    check("rr_rv2", m_rvalid_o, 2'b10);
    check("fp_gnt2", fp_gnt, 2'b01);
    drive(2'b11, 1'b1, 1'b1, 1'b0);
    check("rr_gnt3", m_gnt_o, 2'b10);
    check("rr_rv3", m_rvalid_o, 2'b01);
    check("fp_gnt3", fp_gnt, 2'b01);
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    check("rr_rv4", m_rvalid_o, 2'b10);
    check("fp_rv4", fp_rvalid, 2'b01);
    check("rr_gnt4", m_gnt_o, 2'b00);

    // Master 1 waits for grant; master 0 must not preempt
    do_reset();
    drive(2'b10, 1'b0, 1'b0, 1'b0);
    check("np_req", data_req_o, 1'b1);
    check("np_addr", data_addr_o, A1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b0, 1'b0, 1'b0);
      check("np_state", state_o, S_WGNT);
      check("np_addr_hold", data_addr_o, A1);
      check("np_gnt_none", m_gnt_o, 2'b00);
    end
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    check("np_gnt1", m_gnt_o, 2'b10);
    check("np_we", data_we_o, 1'b1);
    check("np_be", data_be_o, 4'h3);
    check("np_wdata", data_wdata_o, W1);
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    check("np_rv1", m_rvalid_o, 2'b10);

    // Response and new grant in the same cycle, with error on the response
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    check("bb_gnt0", m_gnt_o, 2'b01);
    drive(2'b10, 1'b1, 1'b1, 1'b1);
    check("bb_rv", m_rvalid_o, 2'b01);
    check("bb_err", m_err_o, 2'b01);
    check("bb_gnt", m_gnt_o, 2'b10);
    check("bb_addr", data_addr_o, A1);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("bb_state", state_o, S_WRV);
    check("bb_owner", owner_o, 1'b1);
    check("bb_req_off", data_req_o, 1'b0);
    check("bb_addr_zero", data_addr_o, 32'h0);
    check("bb_busy", busy_o, 1'b1);
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    check("bb_rv1", m_rvalid_o, 2'b10);

    // Owner withdraws in WAIT_GNT: back to IDLE, no protocol error
    drive(2'b01, 1'b0, 1'b0, 1'b0);
    check("wd_gnt", m_gnt_o, 2'b00);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("wd_state", state_o, S_WGNT);
    check("wd_req", data_req_o, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("wd_idle", state_o, S_IDLE);
    check("wd_perr", protocol_err_o, 1'b0);

    // Stray rvalid in IDLE is dropped and latches the protocol error
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    check("sr_rv", m_rvalid_o, 2'b00);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("sr_perr", protocol_err_o, 1'b1);
    for (int i = 0; i < 3; i++) drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("sr_perr_sticky", protocol_err_o, 1'b1);
    do_reset();
    #1;
    check("sr_perr_clr", protocol_err_o, 1'b0);

    // Grant with no request is ignored but flagged
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    check("sg_gnt", m_gnt_o, 2'b00);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("sg_perr", protocol_err_o, 1'b1);
    check("sg_state", state_o, S_IDLE);
    do_reset();

    // Asynchronous reset in WAIT_RVALID, then a late rvalid
    drive(2'b10, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("ar_pre_state", state_o, S_WRV);
    check("ar_pre_owner", owner_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_state", state_o, S_IDLE);
    check("ar_busy", busy_o, 1'b0);
    check("ar_owner", owner_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    check("ar_late_rv", m_rvalid_o, 2'b00);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("ar_late_perr", protocol_err_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
